// File: rtl/leds_arbiter.sv
// Round-robin sequencer for the 8-bit LED register bank: grants masked client
// writes one at a time and interleaves blink writes derived from a shadow copy.
module leds_arbiter #(
    parameter int NREQ      = 3,
    parameter int BLINK_DIV = 50000000,
    parameter int CNT_W     = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_mask,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     gnt,
    input  logic [7:0]          blink_en,
    output logic [7:0]          leds_sel,
    output logic [7:0]          led_input,
    output logic                ram_led,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    // Handshake: a client holds req (level) until it sees its one-cycle gnt
    // pulse; the bank write happens in that same cycle, so req must drop on
    // the following cycle or it is taken as a fresh request.

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_BLINK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [7:0]        sel_q, sel_d;
    logic [7:0]        din_q, din_d;
    logic              ram_q, ram_d;
    logic              busy_q, busy_d;
    logic [7:0]        shadow_q, shadow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic              pend_q, pend_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [7:0]        restore_q, restore_d;
    logic [7:0]        blink_en_q;

    logic              wrap;
    logic [7:0]        left_now;
    logic [PTR_W-1:0]  win;
    logic              win_vld;
    logic [7:0]        mask_w;
    logic [7:0]        data_w;
    logic [PTR_W-1:0]  rr_next;

    // Winner is the first requesting client at or after rr, wrapping modulo NREQ.
    always_comb begin
        win     = rr_q;
        win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = PTR_W'(idx);
            end
        end
    end

    assign mask_w  = req_mask[8*int'(win) +: 8];
    assign data_w  = req_data[8*int'(win) +: 8];
    assign rr_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

    assign wrap     = (cnt_q == CNT_LAST);
    assign cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    assign phase_d  = wrap ? ~phase_q : phase_q;
    // Bits dropped from blink_en while the LEDs are dark must be rewritten later.
    assign left_now = blink_en_q & ~blink_en & {8{phase_q}};

    always_comb begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        sel_d     = '0;
        din_d     = '0;
        shadow_d  = shadow_q;
        rr_d      = rr_q;
        restore_d = restore_q | left_now;
        pend_d    = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d   = ST_BLINK;
                    sel_d     = blink_en | restore_q | left_now;
                    din_d     = phase_q ? (shadow_q & (restore_q | left_now)) : shadow_q;
                    restore_d = '0;
                    pend_d    = 1'b0;
                end else if (win_vld) begin
                    state_d   = ST_WRITE;
                    gnt_d     = NREQ'(1) << win;
                    sel_d     = mask_w;
                    din_d     = data_w;
                    shadow_d  = (shadow_q & ~mask_w) | (data_w & mask_w);
                    rr_d      = rr_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A wrap on the same edge that consumes a pending blink re-arms it.
        if (wrap && ((blink_en != 8'h00) || phase_q)) pend_d = 1'b1;

        ram_d  = din_d[0];
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            din_q      <= '0;
            ram_q      <= 1'b0;
            busy_q     <= 1'b0;
            shadow_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            pend_q     <= 1'b0;
            rr_q       <= '0;
            restore_q  <= '0;
            blink_en_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            din_q      <= din_d;
            ram_q      <= ram_d;
            busy_q     <= busy_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            restore_q  <= restore_d;
            blink_en_q <= blink_en;
        end
    end

    assign gnt       = gnt_q;
    assign leds_sel  = sel_q;
    assign led_input = din_q;
    assign ram_led   = ram_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_leds_arbiter.sv
// Directed bench for leds_arbiter with a short blink period (16 cycles) so
// grant order, blink alternation, collisions and restore writes are all visible.
module tb_leds_arbiter;

    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_mask = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        blink_en = '0;
    logic [7:0]        leds_sel;
    logic [7:0]        led_input;
    logic              ram_led;
    logic              busy;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    leds_arbiter #(.NREQ(NREQ), .BLINK_DIV(16), .CNT_W(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_mask  (req_mask),
        .req_data  (req_data),
        .gnt       (gnt),
        .blink_en  (blink_en),
        .leds_sel  (leds_sel),
        .led_input (led_input),
        .ram_led   (ram_led),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected state encoding: 0 idle, 1 write, 2 blink.
    task automatic chk_all(input string tag, input logic [2:0] e_gnt, input logic [7:0] e_sel,
                           input logic [7:0] e_din, input logic e_busy, input logic [1:0] e_st);
        chk({tag, ".gnt"},   8'(gnt),       8'(e_gnt));
        chk({tag, ".sel"},   leds_sel,      e_sel);
        chk({tag, ".din"},   led_input,     e_din);
        chk({tag, ".ram"},   8'(ram_led),   8'(e_din[0]));
        chk({tag, ".busy"},  8'(busy),      8'(e_busy));
        chk({tag, ".state"}, 8'(dbg_state), 8'(e_st));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req      = '0;
        req_mask = '0;
        req_data = '0;
        blink_en = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        // Reset and quiet idle
        do_reset();
        chk_all("reset", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all("idle", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        end

        // Single masked write from client 1, then read shadow back via blink
        do_reset();
        req      = 3'b010;
        req_mask = {8'h00, 8'hF0, 8'h00};
        req_data = {8'h00, 8'hA5, 8'h00};
        tick();
        chk_all("wr1", 3'b010, 8'hF0, 8'hA5, 1'b1, 2'd1);
        req = '0;
        tick();
        chk_all("wr1_done", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        blink_en = 8'hFF;
        tick_to(16);
        chk_all("pre_blink", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        tick();
        chk_all("blink_off", 3'b000, 8'hFF, 8'h00, 1'b1, 2'd2);
        tick();
        chk_all("blink_off_done", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        tick_to(33);
        chk_all("blink_shadow", 3'b000, 8'hFF, 8'hA0, 1'b1, 2'd2);

        // Blink alternation, collision with client 2, restore after clear
        do_reset();
        req      = 3'b001;
        req_mask = {8'h00, 8'h00, 8'hFF};
        req_data = {8'h00, 8'h00, 8'hFF};
        tick();
        chk_all("fill", 3'b001, 8'hFF, 8'hFF, 1'b1, 2'd1);
        req      = '0;
        blink_en = 8'h03;
        tick_to(17);
        chk_all("blk_a", 3'b000, 8'h03, 8'h00, 1'b1, 2'd2);
        tick_to(33);
        chk_all("blk_b", 3'b000, 8'h03, 8'hFF, 1'b1, 2'd2);
        tick_to(48);
        chk_all("pre_coll", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        req      = 3'b100;
        req_mask = {8'h0F, 8'h00, 8'h00};
        req_data = {8'h5A, 8'h00, 8'h00};
        tick();
        chk_all("coll_blink", 3'b000, 8'h03, 8'h00, 1'b1, 2'd2);
        tick();
        chk_all("coll_gap", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        tick();
        chk_all("coll_write", 3'b100, 8'h0F, 8'h5A, 1'b1, 2'd1);
        req      = '0;
        blink_en = 8'h00;
        tick();
        chk_all("coll_done", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        tick_to(65);
        chk_all("restore", 3'b000, 8'h03, 8'hFA, 1'b1, 2'd2);

        // Round-robin with all clients holding req
        do_reset();
        req      = 3'b111;
        req_mask = {8'hFF, 8'hFF, 8'hFF};
        req_data = {8'h33, 8'h22, 8'h11};
        tick();
        chk_all("rr0", 3'b001, 8'hFF, 8'h11, 1'b1, 2'd1);
        tick();
        chk_all("rr0_gap", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        tick();
        chk_all("rr1", 3'b010, 8'hFF, 8'h22, 1'b1, 2'd1);
        tick();
        chk_all("rr1_gap", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        tick();
        chk_all("rr2", 3'b100, 8'hFF, 8'h33, 1'b1, 2'd1);
        tick();
        chk_all("rr2_gap", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        tick();
        chk_all("rr3", 3'b001, 8'hFF, 8'h11, 1'b1, 2'd1);
        tick();
        tick();
        chk_all("rr4", 3'b010, 8'hFF, 8'h22, 1'b1, 2'd1);
        tick();
        tick();
        chk_all("rr5", 3'b100, 8'hFF, 8'h33, 1'b1, 2'd1);
        tick();
        // Zero mask is still granted
        req      = 3'b001;
        req_mask = {8'hFF, 8'hFF, 8'h00};
        tick();
        chk_all("mask0", 3'b001, 8'h00, 8'h11, 1'b1, 2'd1);
        // Request raised and withdrawn before it can be granted
        req = 3'b010;
        tick();
        chk_all("wd_gap", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        req = '0;
        tick();
        chk_all("withdrawn", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);

        // Reset in the middle of a write
        do_reset();
        req      = 3'b010;
        req_mask = {8'hFF, 8'hFF, 8'hFF};
        req_data = {8'h33, 8'h77, 8'h11};
        tick();
        chk_all("mid_wr", 3'b010, 8'hFF, 8'h77, 1'b1, 2'd1);
        reset = 1'b0;
        req   = 3'b111;
        tick();
        chk_all("mid_rst", 3'b000, 8'h00, 8'h00, 1'b0, 2'd0);
        reset = 1'b1;
        tick();
        chk_all("post_rst", 3'b001, 8'hFF, 8'h11, 1'b1, 2'd1);
        req = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leds_arbiter.md
Name: leds_arbiter

Overview:
Sequencer and arbiter for the board's 8-bit LED register bank. Up to NREQ clients share the bank: the calculator core, the PS/2 status logic and the RAM status path. Each client posts a masked 8-bit write. The block grants clients round-robin and drives the bank's per-bit write-select, data and ram_led inputs. It also time-multiplexes a blink function onto selected LED bits, using a shadow copy of the bank contents.

Parameters:
NREQ, 3, number of requesters (2..8)
BLINK_DIV, 50000000, blink half-period in clk cycles (≥2)
CNT_W, 26, blink counter width; must satisfy 2^CNT_W ≥ BLINK_DIV

Ports:
clk  in  1  system clock (Basys 3 100 MHz)
reset  in  1  synchronous, active-low reset
req  in  NREQ  per-client write request; level, held until gnt
req_mask  in  8*NREQ  client i bits [8i+7:8i]; 1 = write this LED bit
req_data  in  8*NREQ  client i bits [8i+7:8i]; value for masked bits
gnt  out  NREQ  one-hot, one-cycle grant pulse; coincides with the write cycle
blink_en  in  8  LED bits that blink while set
leds_sel  out  8  per-bit write select to LED bank
led_input  out  8  write data to LED bank
ram_led  out  1  write data for LED bit 0 (equals led_input[0])
busy  out  1  high in any non-IDLE state

Behaviour:
- All outputs and state are registered. On clk edge with reset=0:
  - state=IDLE; gnt, leds_sel, led_input, ram_led, busy = 0.
  - shadow=8'h00, blink counter=0, phase=0, blink_pend=0.
  - rr pointer=0, so client 0 has highest priority first.
- Reset mid-write aborts the write. Outputs are 0 on the following cycle.
- States: IDLE, WRITE, BLINK. Each of WRITE and BLINK lasts exactly one cycle, then returns to IDLE. Max throughput is one bank write per 2 cycles.
- IDLE transitions, priority order:
  - blink_pend=1 → BLINK.
  - Else any req bit set → WRITE for winner w. Winner = first set req bit searching from rr upward with wrap-around modulo NREQ.
  - Else stay in IDLE.
- WRITE cycle (outputs valid while state=WRITE):
  - leds_sel=mask_w; led_input=data_w; ram_led=data_w[0]; gnt[w]=1; busy=1.
  - Same edge: shadow[b] ← data_w[b] for every b with mask_w[b]=1. rr ← (w+1) mod NREQ.
- Latency: req[i] first sampled high in IDLE at edge k (no blink pending, i wins) → WRITE and gnt[i] during cycle k+1 → IDLE at k+2. The bank shows the value from edge k+2 onward.
- The client must drop req on the cycle after gnt. req still high in IDLE counts as a new request, ranked behind the rr rotation.
- req dropped before grant withdraws the request; nothing is written.
- mask_w=0 is still granted: gnt pulses, leds_sel=0, shadow unchanged.
- Blink timer:
  - Counter runs freely in every state. Counts 0..BLINK_DIV-1 and wraps to 0.
  - On wrap: phase toggles. If blink_en≠0 or phase was 1, blink_pend ← 1.
  - The final restore write therefore fires after blink_en clears.
- BLINK cycle:
  - leds_sel = blink_en | restore_mask, where restore_mask = bits that left blink_en while phase=1. Tracked in a register; cleared on each BLINK.
  - led_input[b] = phase ? 0 : shadow[b]; ram_led=led_input[0]; gnt=0; blink_pend ← 0.
  - Restore bits are written with shadow[b].
- Blink writes never modify shadow. A client write to a blinking bit updates shadow, and the bank follows client data until the next BLINK.
- A wrap in the same cycle a BLINK is served sets blink_pend again; the blink is not lost.
- BLINK preempts pending requests for one cycle only. No client waits more than NREQ WRITE+IDLE pairs plus one BLINK per wrap.

Test Plan:
- Reset/idle: reset=0 for 2 cycles, then 1, no req → all outputs 0, busy=0, state IDLE for 20 cycles.
- Single write: client 1 req, mask=8'hF0, data=8'hA5 → next cycle gnt=3'b010, leds_sel=F0, led_input=A5, ram_led=1; then outputs 0; shadow=8'hA0.
- Round-robin: all 3 clients hold req continuously → grants 0,1,2,0,1,2 on alternate cycles. Each gnt lasts 1 cycle; no client grant is skipped.
- Blink with BLINK_DIV=4: shadow=8'hFF, blink_en=8'h03 → every 4 cycles a BLINK write with leds_sel=03. led_input alternates 00 / FF (bits 1:0); gnt=0.
- Collision: req from client 2 asserted the same cycle blink_pend sets → BLINK first, WRITE for client 2 two cycles later. Clear blink_en at phase=1 → next wrap writes leds_sel=03, led_input bits = shadow.
- Reset mid-operation: reset=0 during WRITE → next cycle all outputs 0, rr=0. The following request from client 0 is granted first.
